// File: rtl/regfile_wb_controller.sv
// Writeback arbiter and scoreboard for the register file: arbitrates ALU/load
// writebacks onto a single registered RF write port and tracks pending writes.
module regfile_wb_controller #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_writes,
  output logic        iss_stall,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_rd,
  input  logic [31:0] mem_wb_data,
  output logic        mem_wb_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] busy_mask
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic             alu_win, mem_win, xfer, fire;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;

  // MEM normally wins a contended cycle; ALU is forced through once starved.
  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (!reset) begin
      alu_win = alu_wb_valid && (!mem_wb_valid || (starve_q == LIMIT));
      mem_win = mem_wb_valid && !alu_win;
    end
  end

  always_comb begin
    iss_stall = 1'b0;
    if (!reset) begin
      iss_stall = iss_valid &
                  (busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_writes & busy_q[iss_rd]));
    end
  end

  assign alu_wb_ready = alu_win;
  assign mem_wb_ready = mem_win;
  assign xfer         = alu_win | mem_win;
  assign fire         = iss_valid & ~iss_stall;
  assign wb_rd        = alu_win ? alu_wb_rd   : mem_wb_rd;
  assign wb_data      = alu_win ? alu_wb_data : mem_wb_data;

  always_comb begin
    busy_d    = busy_q;
    starve_d  = starve_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;

    // Clear first so a same-edge set on the same register takes priority.
    if (rf_we_q) begin
      busy_d[rf_addr_q] = 1'b0;
    end
    if (fire && iss_writes && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (!alu_wb_valid || alu_win) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end

    if (xfer) begin
      rf_we_d   = (wb_rd != 5'd0);
      rf_addr_d = wb_rd;
      rf_data_d = wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Bench for regfile_wb_controller: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural scoreboard model.
module tb_regfile_wb_controller;

  localparam int LIM = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_valid, iss_writes, iss_stall;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy_mask;

  always #5 clock = ~clock;

  regfile_wb_controller #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_writes(iss_writes), .iss_stall(iss_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .busy_mask(busy_mask)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: which registers await a write, ALU loss streak, RF port.
  logic [31:0] m_busy;
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        last_alu, last_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_writes = 1'b0;
    iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
    alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'd0;
    mem_wb_valid = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 32'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check state.
  task automatic step();
    logic aw, mw, st, fire;
    logic [31:0] nb;
    logic [4:0]  rd;
    #1;
    if (reset) begin
      aw = 1'b0; mw = 1'b0; st = 1'b0;
    end else begin
      aw = alu_wb_valid && (!mem_wb_valid || m_starve == LIM);
      mw = mem_wb_valid && !aw;
      st = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_writes && m_busy[iss_rd]));
    end
    chk("alu_ready", 32'(alu_wb_ready), 32'(aw));
    chk("mem_ready", 32'(mem_wb_ready), 32'(mw));
    chk("iss_stall", 32'(iss_stall), 32'(st));
    last_alu = aw;
    last_mem = mw;
    @(posedge clock);
    if (reset) begin
      m_busy = 32'd0; m_starve = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      fire = iss_valid && !st;
      nb = m_busy;
      if (m_we) nb[m_addr] = 1'b0;
      if (fire && iss_writes && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
      if (aw || mw) begin
        rd     = aw ? alu_wb_rd : mem_wb_rd;
        m_we   = (rd != 5'd0);
        m_addr = rd;
        m_data = aw ? alu_wb_data : mem_wb_data;
      end else begin
        m_we = 1'b0;
      end
      if (!alu_wb_valid || aw) m_starve = 0;
      else if (m_starve < LIM) m_starve = m_starve + 1;
      m_busy = nb;
    end
    #1;
    chk("busy_mask", busy_mask, m_busy);
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_addr", 32'(rf_addr), 32'(m_addr));
    chk("rf_data", rf_data, m_data);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_busy = 32'd0; m_starve = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    last_alu = 1'b0; last_mem = 1'b0;
    step();
    step();
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    reset = 1'b0;

    // Dependent read stalls until the producing writeback commits.
    iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd5;
    step();
    chk("busy5_set", 32'(busy_mask[5]), 32'd1);
    iss_writes = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd5;
    #1 chk("raw_stall", 32'(iss_stall), 32'd1);
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    #1 chk("raw_alu_rdy", 32'(alu_wb_ready), 32'd1);
    step();
    chk("raw_we", 32'(rf_we), 32'd1);
    chk("raw_addr", 32'(rf_addr), 32'd5);
    chk("raw_data", rf_data, 32'hDEADBEEF);
    chk("raw_busy_held", 32'(busy_mask[5]), 32'd1);
    alu_wb_valid = 1'b0;
    #1 chk("raw_stall_hold", 32'(iss_stall), 32'd1);
    step();
    chk("raw_busy_clr", 32'(busy_mask[5]), 32'd0);
    #1 chk("raw_stall_drop", 32'(iss_stall), 32'd0);
    step();
    idle();

    // Writeback to x0 is consumed without a write.
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'h12345678;
    #1 chk("x0_mem_rdy", 32'(mem_wb_ready), 32'd1);
    step();
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    idle();

    // Fill every register, then an all-x0 instruction must not stall.
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'(r);
      step();
    end
    chk("fill_busy", busy_mask, 32'hFFFFFFFE);
    iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    #1 chk("x0_nostall", 32'(iss_stall), 32'd0);
    step();
    chk("x0_busy_keep", busy_mask, 32'hFFFFFFFE);

    // Re-claim x7 right after its write commits.
    idle();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = $urandom;
    step();
    alu_wb_valid = 1'b0;
    iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd7;
    #1 chk("x7_waw_stall", 32'(iss_stall), 32'd1);
    step();
    chk("x7_clr", 32'(busy_mask[7]), 32'd0);
    #1 chk("x7_nostall", 32'(iss_stall), 32'd0);
    step();
    chk("x7_reset", 32'(busy_mask[7]), 32'd1);
    idle();

    // Reset right after a transfer drops the pending write.
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = $urandom;
    step();
    reset = 1'b1;
    alu_wb_valid = 1'b1; iss_valid = 1'b1; iss_rs1 = 5'd1;
    #1;
    chk("rst_alu_rdy", 32'(alu_wb_ready), 32'd0);
    chk("rst_mem_rdy", 32'(mem_wb_ready), 32'd0);
    chk("rst_stall", 32'(iss_stall), 32'd0);
    step();
    chk("rst_mid_we", 32'(rf_we), 32'd0);
    chk("rst_mid_busy", busy_mask, 32'd0);
    reset = 1'b0;
    idle();
    step();
    chk("rst_post_we", 32'(rf_we), 32'd0);

    // Continuous contention: three MEM grants then one forced ALU grant.
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'hA0A0A0A0;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd4; mem_wb_data = 32'h0B0B0B0B;
    for (int i = 0; i < 8; i++) begin
      #1 chk("grant_seq", 32'(alu_wb_ready), 32'((i % 4) == 3));
      step();
    end
    idle();
    step();

    // Randomized traffic; requesters hold their payload until accepted.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (!alu_wb_valid || last_alu) begin
        alu_wb_valid = ($urandom_range(0, 2) != 0);
        alu_wb_rd    = 5'($urandom_range(0, 7));
        alu_wb_data  = $urandom;
      end
      if (!mem_wb_valid || last_mem) begin
        mem_wb_valid = ($urandom_range(0, 2) != 0);
        mem_wb_rd    = 5'($urandom_range(0, 7));
        mem_wb_data  = $urandom;
      end
      iss_valid  = ($urandom_range(0, 1) != 0);
      iss_writes = ($urandom_range(0, 1) != 0);
      iss_rs1    = 5'($urandom_range(0, 7));
      iss_rs2    = 5'($urandom_range(0, 7));
      iss_rd     = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
